// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder for the RV32 MEM stage: lw/sw served from
// an internal RAM after LATENCY wait cycles, with pipeline stall and one-cycle ack.
//
// state  | meaning
// IDLE   | no request in flight; aligned ce_i is captured, misaligned ce_i errors out
// WAIT   | counting down wait cycles; array access on the edge where cnt reaches 0
// RESP   | ack_o high for this single cycle; stall released so the pipeline advances
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        misalign_o,
  output logic        stall_o
);

  localparam int              LP_WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0]      LP_LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_rdata;
  logic                  r_ack;
  logic                  r_misalign;

  logic [31:0]           r_mem [0:LP_WORDS-1];

  logic                  w_aligned;
  logic                  w_accept;
  logic                  w_misal;
  logic                  w_cnt_done;
  logic                  w_access;
  logic                  w_unused_addr;

  // Upper address bits only alias the array; they are intentionally dropped.
  assign w_unused_addr = ^addr_i[31:DEPTH_LOG2+2];

  assign w_aligned  = (addr_i[1:0] == 2'b00);
  assign w_accept   = (r_state == S_IDLE) && ce_i && w_aligned;
  assign w_misal    = (r_state == S_IDLE) && ce_i && !w_aligned;
  assign w_cnt_done = (r_cnt == 4'd0);
  assign w_access   = (r_state == S_WAIT) && w_cnt_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_WAIT;
        end else if (w_misal) begin
          w_next = S_RESP;
        end
      end
      S_WAIT: begin
        if (w_cnt_done) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_rdata    <= 32'd0;
      r_ack      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_ack      <= (w_next == S_RESP);
      r_misalign <= w_misal;
      if (w_accept) begin
        r_cnt <= LP_LAT;
      end else if ((r_state == S_WAIT) && !w_cnt_done) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_misal) begin
        r_rdata <= 32'd0;
      end else if (w_access && !r_we) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // Request fields are frozen at acceptance so later bus activity cannot leak in.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we_i;
      r_wdata <= wdata_i;
      r_idx   <= addr_i[DEPTH_LOG2+1:2];
    end
  end

  // rst wins over a write landing on the same edge, so aborted stores are dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign rdata_o    = r_rdata;
  assign ack_o      = r_ack;
  assign misalign_o = r_misalign;
  assign stall_o    = ((r_state == S_IDLE) && ce_i) || (r_state == S_WAIT);

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the pipelined RV32 core. It serves the word-access requests (lw/sw) that the MEM stage issues over its ce/we/addr/wdata interface. Requests are served from an internal word-addressed RAM with a configurable number of wait states. While a request is in flight it holds the pipeline with a stall signal, and it returns read data with a one-cycle acknowledge.

## Interface
- DEPTH_LOG2, 10: log2 of RAM depth in 32-bit words (1024 words).
- LATENCY, 2: wait cycles inserted before the array access; legal range 0..15.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-high.
- ce_i  input  1  request strobe from MEM stage (high for lw or sw).
- we_i  input  1  1 = write (sw), 0 = read (lw); sampled only with ce_i.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data.
- rdata_o  output  32  load data; registered.
- ack_o  output  1  one-cycle completion pulse; registered.
- misalign_o  output  1  completion was a misaligned-address error; registered, valid with ack_o.
- stall_o  output  1  pipeline hold; combinational.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. A 4-bit down-counter cnt tracks wait cycles.
- IDLE:
  - If ce_i=1 and addr_i[1:0]=00, the block captures we_i, wdata_i and word index addr_i[DEPTH_LOG2+1:2]. It loads cnt=LATENCY and moves to WAIT.
  - If ce_i=1 and addr_i[1:0]≠00, no array access occurs. The block moves to RESP with misalign_o=1 and rdata_o=0.
  - If ce_i=0, the FSM stays in IDLE.
- WAIT:
  - If cnt≠0, cnt decrements.
  - If cnt=0, the array access happens at this clock edge. A write stores the captured wdata. A read loads rdata_o with the array word. The FSM then moves to RESP.
- RESP:
  - ack_o=1 for exactly this cycle. The FSM moves to IDLE unconditionally.
  - The request visible on ce_i during RESP is the completed one. It is not re-accepted.
- stall_o = (state==IDLE && ce_i) || state==WAIT. stall_o is 0 in RESP, so the pipeline advances on that edge.
- Address bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4·2^DEPTH_LOG2 bytes.
- Captured request fields are held for the whole transaction. Changes on ce_i, we_i, addr_i or wdata_i after acceptance are ignored.
- On writes, rdata_o keeps its previous value. On a misaligned completion, rdata_o=0.
- misalign_o is 0 on every aligned completion and 0 outside RESP.
- RAM contents are not reset and are undefined after power-up.

## Timing
- Reset values: state=IDLE, cnt=0, rdata_o=0, ack_o=0, misalign_o=0. stall_o follows ce_i from the first post-reset cycle.
- rst asserted mid-transaction aborts it. A write still in WAIT with cnt>0, or in WAIT with cnt=0 on the same edge as rst, is dropped because rst has priority. No ack_o is produced for an aborted transaction.
- Aligned request accepted in IDLE at cycle T:
  - WAIT occupies cycles T+1..T+1+LATENCY.
  - The access happens on the edge ending T+1+LATENCY.
  - ack_o is high in cycle T+2+LATENCY.
  - stall_o is high for LATENCY+2 cycles (T..T+1+LATENCY).
- Misaligned request at T: ack_o and misalign_o are high at T+1. stall_o is high for 1 cycle.
- Back-to-back: the cycle after RESP is IDLE, so a new request is accepted at T+3+LATENCY at the earliest.
- A read of the word just written returns the new data, because the write completes before the later request is accepted.

## Test plan
- Reset, then aligned sw addr=0x0000_0010 wdata=0xDEADBEEF with LATENCY=2:
  - stall_o is high for 4 cycles.
  - ack_o pulses once in cycle 5.
  - misalign_o=0.
  - rdata_o is unchanged (0).
- Then lw addr=0x0000_0010: ack_o in cycle 5 after acceptance, with rdata_o=0xDEADBEEF.
- lw addr=0x0000_0012: ack_o and misalign_o high one cycle after acceptance, rdata_o=0, stall_o high for 1 cycle. The RAM word at index 4 is still 0xDEADBEEF.
- Aliasing with DEPTH_LOG2=10: sw addr=0x0000_1004 data=0x12345678, then lw addr=0x0000_0004 returns 0x12345678.
- LATENCY=0: lw is accepted at T and ack_o arrives at T+2. Back-to-back sw then lw to the same address returns the stored value, with no ack_o overlap.
- sw addr=0x20 data=0xAAAA5555 with rst pulsed during the first WAIT cycle:
  - No ack_o is produced.
  - All outputs return to reset values.
  - A subsequent lw 0x20 returns the pre-existing contents, not 0xAAAA5555.
